// File: rtl/seq_sub_36b.sv
// Serial 36-bit subtractor: computes A - B - Bin one 4-bit slice per clock,
// LSB slice first, with a one-cycle done pulse when D/Bout/V update.
module seq_sub_36b (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [35:0] A,
    input  logic [35:0] B,
    input  logic        Bin,
    output logic [35:0] D,
    output logic        Bout,
    output logic        V,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        carry;
    logic [35:0] a_sh;
    logic [35:0] b_sh;
    logic        a_msb;
    logic        b_msb;
    logic [31:0] res;
    logic [4:0]  slice_sum;
    logic [35:0] res_nxt;
    logic        accept;

    assign accept    = start && (state != S_RUN);
    assign slice_sum = {1'b0, a_sh[3:0]} + {1'b0, ~b_sh[3:0]} + {4'b0, carry};
    // Operands shift right each slice; result bits enter from the top so the
    // ninth slice completes the word without any variable indexing.
    assign res_nxt   = {slice_sum[3:0], res};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == 4'd8) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            res   <= '0;
            D     <= '0;
            Bout  <= 1'b0;
            V     <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= ~Bin;
            a_sh  <= A;
            b_sh  <= B;
            a_msb <= A[35];
            b_msb <= B[35];
            res   <= '0;
        end else if (state == S_RUN) begin
            cnt   <= cnt + 4'd1;
            carry <= slice_sum[4];
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            res   <= res_nxt[35:4];
            if (cnt == 4'd8) begin
                D    <= res_nxt;
                Bout <= ~slice_sum[4];
                V    <= (a_msb != b_msb) && (res_nxt[35] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_seq_sub_36b.sv
// Directed self-checking bench for seq_sub_36b with hand-computed results.
module tb_seq_sub_36b;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [35:0] A;
    logic [35:0] B;
    logic        Bin;
    logic [35:0] D;
    logic        Bout;
    logic        V;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    seq_sub_36b dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .D    (D),
        .Bout (Bout),
        .V    (V),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; inj > 0 pulses start with all-ones operands after that edge.
    task automatic op(input string tag, input logic [35:0] a, input logic [35:0] b,
                      input logic bi, input logic [35:0] ed, input logic eb,
                      input logic ev, input int inj);
        logic [35:0] prev_d;
        int edges;
        int bc;
        prev_d = D;
        A = a; B = b; Bin = bi; start = 1'b1;
        tick();
        start = 1'b0;
        A = ~a; B = ~b; Bin = ~bi;
        edges = 1;
        bc = 0;
        while (done !== 1'b1 && edges < 20) begin
            if (busy === 1'b1) bc++;
            if (edges == 5) chk({tag, "_dhold"}, D, prev_d);
            if (edges == inj) begin
                start = 1'b1; A = '1; B = '1;
            end else begin
                start = 1'b0;
            end
            tick();
            edges++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 36'(edges), 36'd10);
        chk({tag, "_busycyc"}, 36'(bc), 36'd9);
        chk({tag, "_D"}, D, ed);
        chk({tag, "_Bout"}, {35'b0, Bout}, {35'b0, eb});
        chk({tag, "_V"}, {35'b0, V}, {35'b0, ev});
        tick();
        chk({tag, "_donewidth"}, {35'b0, done}, 36'd0);
        chk({tag, "_idlebusy"}, {35'b0, busy}, 36'd0);
        chk({tag, "_Dkeep"}, D, ed);
    endtask

    initial begin
        int e;
        int ndone;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("rst_D", D, 36'd0);
        chk("rst_Bout", {35'b0, Bout}, 36'd0);
        chk("rst_V", {35'b0, V}, 36'd0);
        chk("rst_busy", {35'b0, busy}, 36'd0);
        chk("rst_done", {35'b0, done}, 36'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_busy", {35'b0, busy}, 36'd0);

        op("s1_5m3", 36'h0_0000_0005, 36'h0_0000_0003, 1'b0, 36'h0_0000_0002, 1'b0, 1'b0, 5);
        op("s2_0m1", 36'h0, 36'h0_0000_0001, 1'b0, 36'hF_FFFF_FFFF, 1'b1, 1'b0, 0);
        op("s3_ovf", 36'h8_0000_0000, 36'h0_0000_0001, 1'b0, 36'h7_FFFF_FFFF, 1'b0, 1'b1, 0);
        op("s4_rip", 36'h1_0000_0000, 36'h0, 1'b1, 36'h0_FFFF_FFFF, 1'b0, 1'b0, 0);
        op("s5_mix", 36'h1_2345_6789, 36'h9_8765_4321, 1'b1, 36'h7_9BE0_2467, 1'b1, 1'b0, 0);

        // Reset while cnt=3 of a new operation.
        A = 36'h0_0000_0100; B = 36'h0_0000_0001; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("mid_busy_pre", {35'b0, busy}, 36'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {35'b0, busy}, 36'd0);
        chk("mid_rst_done", {35'b0, done}, 36'd0);
        chk("mid_rst_D", D, 36'd0);
        chk("mid_rst_Bout", {35'b0, Bout}, 36'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("mid_rst_nodone", 36'(ndone), 36'd0);

        // Back-to-back: start held high through DONE.
        A = 36'h0_0000_0005; B = 36'h0_0000_0003; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        e = 1;
        while (done !== 1'b1 && e < 20) begin
            tick();
            e++;
        end
        chk("b2b_lat1", 36'(e), 36'd10);
        chk("b2b_D1", D, 36'h0_0000_0002);
        A = 36'h0_0000_0010; B = 36'h0_0000_0001; Bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_rerun_busy", {35'b0, busy}, 36'd1);
        chk("b2b_rerun_done", {35'b0, done}, 36'd0);
        chk("b2b_Dhold", D, 36'h0_0000_0002);
        e = 1;
        while (done !== 1'b1 && e < 20) begin
            tick();
            e++;
        end
        chk("b2b_gap", 36'(e + 1), 36'd11);
        chk("b2b_D2", D, 36'h0_0000_000F);
        chk("b2b_Bout2", {35'b0, Bout}, 36'd0);
        chk("b2b_V2", {35'b0, V}, 36'd0);
        tick();
        chk("b2b_idle", {35'b0, done}, 36'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
